// File: rtl/ex_mem_dual.sv
// Dual-issue EX/MEM pipeline register with branch resolution, PC redirect and front-end flush window.
// Optional branch statistics counters are enabled with `EX_MEM_BRANCH_STATS_EN.
module ex_mem_dual #(
    parameter int FLUSH_CYCLES = 2,
    parameter int STAT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        valid1_EX,
    input  logic        valid2_EX,
    input  logic        taken1,
    input  logic        taken2,
    input  logic [31:0] branchTarget1,
    input  logic [31:0] branchTarget2,
    input  logic [31:0] aluRes1,
    input  logic [31:0] aluRes2,
    input  logic [31:0] storeData1,
    input  logic [31:0] storeData2,
    input  logic        regWrite1_EX,
    input  logic        regWrite2_EX,
    input  logic        memRead1_EX,
    input  logic        memRead2_EX,
    input  logic        memWrite1_EX,
    input  logic        memWrite2_EX,
    input  logic [4:0]  writeReg1_EX,
    input  logic [4:0]  writeReg2_EX,
`ifdef EX_MEM_BRANCH_STATS_EN
    input  logic        Branch1,
    input  logic        Branch2,
    output logic [STAT_W-1:0] branchCount,
    output logic [STAT_W-1:0] redirectCount,
`endif
    output logic        valid1_MEM,
    output logic        valid2_MEM,
    output logic [31:0] aluRes1_MEM,
    output logic [31:0] aluRes2_MEM,
    output logic [31:0] storeData1_MEM,
    output logic [31:0] storeData2_MEM,
    output logic        regWrite1_MEM,
    output logic        regWrite2_MEM,
    output logic        memRead1_MEM,
    output logic        memRead2_MEM,
    output logic        memWrite1_MEM,
    output logic        memWrite2_MEM,
    output logic [4:0]  writeReg1_MEM,
    output logic [4:0]  writeReg2_MEM,
    output logic        redirect,
    output logic [31:0] redirectPC,
    output logic        flushFront
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    logic [3:0] flush_cnt;
    logic       flushing;
    logic       v1;
    logic       v2;
    logic       take1;
    logic       take2;

    // Instructions arriving while the window is open are wrong-path, so they are invalidated here.
    assign flushing   = (flush_cnt != 4'd0);
    assign v1         = valid1_EX & ~flushing;
    assign v2         = valid2_EX & ~flushing & ~(v1 & taken1);
    assign take1      = v1 & taken1;
    assign take2      = v2 & taken2;
    assign flushFront = flushing;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid1_MEM     <= 1'b0;
            valid2_MEM     <= 1'b0;
            aluRes1_MEM    <= 32'd0;
            aluRes2_MEM    <= 32'd0;
            storeData1_MEM <= 32'd0;
            storeData2_MEM <= 32'd0;
            regWrite1_MEM  <= 1'b0;
            regWrite2_MEM  <= 1'b0;
            memRead1_MEM   <= 1'b0;
            memRead2_MEM   <= 1'b0;
            memWrite1_MEM  <= 1'b0;
            memWrite2_MEM  <= 1'b0;
            writeReg1_MEM  <= 5'd0;
            writeReg2_MEM  <= 5'd0;
            redirect       <= 1'b0;
            redirectPC     <= 32'd0;
        end else if (stall) begin
            redirect <= 1'b0;
        end else begin
            valid1_MEM     <= v1;
            valid2_MEM     <= v2;
            aluRes1_MEM    <= aluRes1;
            aluRes2_MEM    <= aluRes2;
            storeData1_MEM <= storeData1;
            storeData2_MEM <= storeData2;
            regWrite1_MEM  <= regWrite1_EX & v1;
            regWrite2_MEM  <= regWrite2_EX & v2;
            memRead1_MEM   <= memRead1_EX & v1;
            memRead2_MEM   <= memRead2_EX & v2;
            memWrite1_MEM  <= memWrite1_EX & v1;
            memWrite2_MEM  <= memWrite2_EX & v2;
            writeReg1_MEM  <= writeReg1_EX;
            writeReg2_MEM  <= writeReg2_EX;
            // The branching instruction itself still commits; only the target selection has priority.
            if (take1) begin
                redirect   <= 1'b1;
                redirectPC <= branchTarget1;
            end else if (take2) begin
                redirect   <= 1'b1;
                redirectPC <= branchTarget2;
            end else begin
                redirect <= 1'b0;
            end
        end
    end

    // The counter keeps draining under stall so the window length is counted in wall-clock cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flush_cnt <= 4'd0;
        end else if (!stall && (take1 || take2)) begin
            flush_cnt <= FLUSH_LOAD;
        end else if (flushing) begin
            flush_cnt <= flush_cnt - 4'd1;
        end
    end

`ifdef EX_MEM_BRANCH_STATS_EN
    logic [1:0]      branch_inc;
    logic [STAT_W:0] branch_sum;

    assign branch_inc = {1'b0, v1 & Branch1} + {1'b0, v2 & Branch2};
    assign branch_sum = {1'b0, branchCount} + {{(STAT_W-1){1'b0}}, branch_inc};

    always_ff @(posedge clk) begin
        if (!rst) begin
            branchCount   <= '0;
            redirectCount <= '0;
        end else begin
            if (!stall) begin
                branchCount <= branch_sum[STAT_W] ? {STAT_W{1'b1}} : branch_sum[STAT_W-1:0];
            end
            if (redirect && (redirectCount != {STAT_W{1'b1}})) begin
                redirectCount <= redirectCount + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_dual.sv
// Scoreboard bench for ex_mem_dual: directed vectors push hand-computed expectations, a monitor pops and compares.
module tb_ex_mem_dual;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        valid1_EX = 1'b0, valid2_EX = 1'b0, taken1 = 1'b0, taken2 = 1'b0;
    logic [31:0] branchTarget1 = 32'd0, branchTarget2 = 32'd0;
    logic [31:0] aluRes1 = 32'd0, aluRes2 = 32'd0;
    logic [31:0] storeData1, storeData2;
    logic [4:0]  writeReg1_EX, writeReg2_EX;
    logic        ctl = 1'b1;
    logic        valid1_MEM, valid2_MEM;
    logic [31:0] aluRes1_MEM, aluRes2_MEM, storeData1_MEM, storeData2_MEM;
    logic        regWrite1_MEM, regWrite2_MEM, memRead1_MEM, memRead2_MEM, memWrite1_MEM, memWrite2_MEM;
    logic [4:0]  writeReg1_MEM, writeReg2_MEM;
    logic        redirect, flushFront;
    logic [31:0] redirectPC;
`ifdef EX_MEM_BRANCH_STATS_EN
    logic [15:0] branchCount, redirectCount;
`endif

    // Secondary data fields are derived from the ALU results so the expectation follows from e_a1/e_a2.
    assign storeData1   = {aluRes1[15:0], aluRes1[31:16]};
    assign storeData2   = {aluRes2[15:0], aluRes2[31:16]};
    assign writeReg1_EX = aluRes1[4:0];
    assign writeReg2_EX = aluRes2[4:0];

    always #5 clk = ~clk;

    ex_mem_dual #(.FLUSH_CYCLES(2), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .valid1_EX(valid1_EX), .valid2_EX(valid2_EX), .taken1(taken1), .taken2(taken2),
        .branchTarget1(branchTarget1), .branchTarget2(branchTarget2),
        .aluRes1(aluRes1), .aluRes2(aluRes2), .storeData1(storeData1), .storeData2(storeData2),
        .regWrite1_EX(ctl), .regWrite2_EX(ctl), .memRead1_EX(ctl), .memRead2_EX(ctl),
        .memWrite1_EX(ctl), .memWrite2_EX(ctl),
        .writeReg1_EX(writeReg1_EX), .writeReg2_EX(writeReg2_EX),
`ifdef EX_MEM_BRANCH_STATS_EN
        .Branch1(taken1), .Branch2(taken2),
        .branchCount(branchCount), .redirectCount(redirectCount),
`endif
        .valid1_MEM(valid1_MEM), .valid2_MEM(valid2_MEM),
        .aluRes1_MEM(aluRes1_MEM), .aluRes2_MEM(aluRes2_MEM),
        .storeData1_MEM(storeData1_MEM), .storeData2_MEM(storeData2_MEM),
        .regWrite1_MEM(regWrite1_MEM), .regWrite2_MEM(regWrite2_MEM),
        .memRead1_MEM(memRead1_MEM), .memRead2_MEM(memRead2_MEM),
        .memWrite1_MEM(memWrite1_MEM), .memWrite2_MEM(memWrite2_MEM),
        .writeReg1_MEM(writeReg1_MEM), .writeReg2_MEM(writeReg2_MEM),
        .redirect(redirect), .redirectPC(redirectPC), .flushFront(flushFront)
    );

    typedef struct {
        logic        v1, v2, red, flush;
        logic [31:0] rpc, a1, a2;
    } expect_t;

    expect_t exp_q[$];
    int checks = 0;
    int passed = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    // Control inputs are all tied high, so every qualified control output must equal its slot valid.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            expect_t e;
            e = exp_q.pop_front();
            check_output("valid1_MEM", 32'(valid1_MEM), 32'(e.v1));
            check_output("valid2_MEM", 32'(valid2_MEM), 32'(e.v2));
            check_output("regWrite1_MEM", 32'(regWrite1_MEM), 32'(e.v1));
            check_output("regWrite2_MEM", 32'(regWrite2_MEM), 32'(e.v2));
            check_output("memRead1_MEM", 32'(memRead1_MEM), 32'(e.v1));
            check_output("memRead2_MEM", 32'(memRead2_MEM), 32'(e.v2));
            check_output("memWrite1_MEM", 32'(memWrite1_MEM), 32'(e.v1));
            check_output("memWrite2_MEM", 32'(memWrite2_MEM), 32'(e.v2));
            check_output("aluRes1_MEM", aluRes1_MEM, e.a1);
            check_output("aluRes2_MEM", aluRes2_MEM, e.a2);
            check_output("storeData1_MEM", storeData1_MEM, {e.a1[15:0], e.a1[31:16]});
            check_output("storeData2_MEM", storeData2_MEM, {e.a2[15:0], e.a2[31:16]});
            check_output("writeReg1_MEM", 32'(writeReg1_MEM), 32'(e.a1[4:0]));
            check_output("writeReg2_MEM", 32'(writeReg2_MEM), 32'(e.a2[4:0]));
            check_output("redirect", 32'(redirect), 32'(e.red));
            check_output("redirectPC", redirectPC, e.rpc);
            check_output("flushFront", 32'(flushFront), 32'(e.flush));
        end
    end

    task automatic apply_stimulus(
        input logic r, input logic st, input logic iv1, input logic iv2,
        input logic tk1, input logic tk2, input logic [31:0] t1, input logic [31:0] t2,
        input logic [31:0] a1, input logic [31:0] a2,
        input logic ev1, input logic ev2, input logic ered, input logic [31:0] erpc,
        input logic efl, input logic [31:0] ea1, input logic [31:0] ea2);
        expect_t e;
        @(negedge clk);
        rst = r; stall = st; valid1_EX = iv1; valid2_EX = iv2; taken1 = tk1; taken2 = tk2;
        branchTarget1 = t1; branchTarget2 = t2; aluRes1 = a1; aluRes2 = a2;
        e.v1 = ev1; e.v2 = ev2; e.red = ered; e.rpc = erpc; e.flush = efl; e.a1 = ea1; e.a2 = ea2;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    initial begin
        // Reset dominates stall with every input high
        apply_stimulus(0,1, 1,1, 1,1, ONES,ONES, ONES,ONES,  0,0,0,32'h0,0, 32'h0,32'h0);
        apply_stimulus(1,0, 0,0, 0,0, 0,0, 32'h11,32'h22,      0,0,0,32'h0,0, 32'h11,32'h22);
        apply_stimulus(1,0, 1,1, 0,0, 0,0, 32'h10,32'h20,      1,1,0,32'h0,0, 32'h10,32'h20);
        // Slot-1 taken squashes slot 2, then wrong-path branch during the window
        apply_stimulus(1,0, 1,1, 1,0, 32'h100,0, 32'h31,32'h32, 1,0,1,32'h100,1, 32'h31,32'h32);
        apply_stimulus(1,0, 1,0, 1,0, 32'h300,0, 32'h41,32'h42, 0,0,0,32'h100,1, 32'h41,32'h42);
        apply_stimulus(1,0, 0,0, 0,0, 0,0, 32'h51,32'h52,       0,0,0,32'h100,0, 32'h51,32'h52);
        // Slot-2 taken only
        apply_stimulus(1,0, 1,1, 0,1, 0,32'h200, 32'h61,32'h55, 1,1,1,32'h200,1, 32'h61,32'h55);
        apply_stimulus(1,0, 0,0, 0,0, 0,0, 32'h71,32'h72,       0,0,0,32'h200,1, 32'h71,32'h72);
        apply_stimulus(1,0, 0,0, 0,0, 0,0, 32'h81,32'h82,       0,0,0,32'h200,0, 32'h81,32'h82);
        // Both taken: slot-1 target wins
        apply_stimulus(1,0, 1,1, 1,1, 32'h100,32'h200, 32'h91,32'h92, 1,0,1,32'h100,1, 32'h91,32'h92);
        apply_stimulus(1,0, 0,0, 0,0, 0,0, 32'hA1,32'hA2,       0,0,0,32'h100,1, 32'hA1,32'hA2);
        apply_stimulus(1,0, 0,0, 0,0, 0,0, 32'hB1,32'hB2,       0,0,0,32'h100,0, 32'hB1,32'hB2);
        // Stall freezes MEM and blocks resolution; release loads current inputs
        apply_stimulus(1,1, 1,1, 1,0, 32'h400,0, 32'hC1,32'hC2, 0,0,0,32'h100,0, 32'hB1,32'hB2);
        apply_stimulus(1,1, 1,1, 1,0, 32'h404,0, 32'hD1,32'hD2, 0,0,0,32'h100,0, 32'hB1,32'hB2);
        apply_stimulus(1,1, 1,1, 1,0, 32'h408,0, 32'hE1,32'hE2, 0,0,0,32'h100,0, 32'hB1,32'hB2);
        apply_stimulus(1,0, 1,1, 1,0, 32'h40C,0, 32'hF1,32'hF2, 1,0,1,32'h40C,1, 32'hF1,32'hF2);
        // Stall inside the window: held outputs, redirect drops, counter still drains
        apply_stimulus(1,1, 1,1, 1,0, 32'h410,0, 32'h111,32'h112, 1,0,0,32'h40C,1, 32'hF1,32'hF2);
        apply_stimulus(1,0, 0,0, 0,0, 0,0, 32'h121,32'h122,     0,0,0,32'h40C,0, 32'h121,32'h122);
        // Reset in the middle of a flush window
        apply_stimulus(1,0, 1,0, 1,0, 32'h500,0, 32'h131,32'h132, 1,0,1,32'h500,1, 32'h131,32'h132);
        apply_stimulus(0,0, 1,1, 0,0, 0,0, 32'h141,32'h142,     0,0,0,32'h0,0, 32'h0,32'h0);
        apply_stimulus(1,0, 0,0, 0,0, 0,0, 32'h151,32'h152,     0,0,0,32'h0,0, 32'h151,32'h152);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
